// File: rtl/sevenseg_capture.sv
// sevenseg_capture: decodes a multiplexed seven-segment scan back into published frames
//   clk, rst (async, active-high)
//   anode_l[7:0], segs_l[6:0] (bit0=a..bit6=g), dp_l : active-low display lines
//   clear        : synchronous clear of sticky seg_err/multi_err
//   digits[31:0], blank[7:0], dpmask[7:0], frame_valid : frame published once per FRAME_CYC
//   seg_err, multi_err : sticky error flags
//   changed      : pulses with frame_valid when the frame differs from the previous one
//                  (only with SEVENSEG_CAPTURE_CHANGE_EN defined, else tied to 0)
module sevenseg_capture #(
  parameter int STABLE_CYC = 1,
  parameter int FRAME_CYC  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  anode_l,
  input  logic [6:0]  segs_l,
  input  logic        dp_l,
  input  logic        clear,
  output logic [31:0] digits,
  output logic [7:0]  blank,
  output logic [7:0]  dpmask,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        multi_err,
  output logic        changed
);
  localparam logic [3:0] SC = 4'(STABLE_CYC);
  localparam logic [7:0] FL = 8'(FRAME_CYC - 1);

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  logic [15:0] in_w, s;
  logic [3:0]  run;
  logic        done;
  logic [7:0]  cnt;
  logic [7:0]  seen, dps, n_seen, n_dp, an;
  logic [31:0] dig, n_dig;
  logic [4:0]  dec;
  logic        one, acc, pub;

  assign in_w = {anode_l, segs_l, dp_l};
  assign an   = ~s[15:8];
  assign one  = $onehot(an);
  // done blocks repeat accepts once the run counter saturates within one dwell
  assign acc  = (run == SC) && !done;
  assign pub  = cnt == FL;
  assign dec  = decode(~s[7:1]);

  // staging with the current accept merged, so a publish-cycle accept lands in the frame
  always_comb begin
    n_seen = seen;
    n_dp   = dps;
    n_dig  = dig;
    for (int i = 0; i < 8; i++)
      if (acc && one && an[i]) begin
        n_seen[i]       = 1'b1;
        n_dp[i]         = ~s[0];
        n_dig[4*i +: 4] = dec[3:0];
      end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s           <= '0;
      run         <= '0;
      done        <= 1'b0;
      cnt         <= '0;
      seen        <= '0;
      dps         <= '0;
      dig         <= '0;
      digits      <= '0;
      blank       <= 8'hFF;
      dpmask      <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      multi_err   <= 1'b0;
    end else begin
      s           <= in_w;
      run         <= in_w != s ? 4'd1 : run == 4'd15 ? run : run + 4'd1;
      done        <= in_w != s ? 1'b0 : done | acc;
      cnt         <= pub ? 8'd0 : cnt + 8'd1;
      seen        <= pub ? 8'd0 : n_seen;
      dps         <= pub ? 8'd0 : n_dp;
      dig         <= pub ? 32'd0 : n_dig;
      frame_valid <= pub;
      seg_err     <= (acc && one && !dec[4]) || (seg_err && !clear);
      multi_err   <= (acc && |an && !one) || (multi_err && !clear);
      if (pub) begin
        digits <= n_dig;
        blank  <= ~n_seen;
        dpmask <= n_dp;
      end
    end

`ifdef SEVENSEG_CAPTURE_CHANGE_EN
  logic [47:0] prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev    <= {32'd0, 8'hFF, 8'd0};
      changed <= 1'b0;
    end else begin
      changed <= pub && ({n_dig, ~n_seen, n_dp} != prev);
      if (pub) prev <= {n_dig, ~n_seen, n_dp};
    end
`else
  assign changed = 1'b0;
`endif
endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
Receive-side counterpart of the multiplexed seven-segment driver. It samples the time-multiplexed anode, segment and decimal-point lines and decodes segment patterns back to hex nibbles. It rebuilds per-digit value, blank and dp masks, and publishes one complete frame per scan window. It is used as an on-chip loopback checker and as a bench monitor for display logic.

Parameters:
STABLE_CYC, 1, consecutive identical registered samples required before a sample is accepted (1..15).
FRAME_CYC, 8, cycles per publication window (must be >= 8*STABLE_CYC, <= 255).

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  asynchronous, active-high reset.
anode_l  in  8  digit enables, active low; bit i = digit i.
segs_l  in  7  segments, active low; bit0=a .. bit6=g.
dp_l  in  1  decimal point, active low.
clear  in  1  synchronous clear of sticky error flags.
digits  out  32  published nibbles; digit i at [4i+3:4i].
blank  out  8  published blank mask; 1 = digit not seen in frame.
dpmask  out  8  published dp mask; 1 = dp lit on that digit.
frame_valid  out  1  one-cycle pulse; outputs updated on this edge.
seg_err  out  1  sticky; accepted pattern not in hex table.
multi_err  out  1  sticky; accepted sample had >1 anode low.
changed  out  1  see Optional Feature.

Behaviour:
- Reset (async): digits=0, blank=8'hFF, dpmask=0, frame_valid=0, seg_err=0, multi_err=0, changed=0. Sample register, run counter, frame timer and staging are all cleared.
- Input stage: {anode_l,segs_l,dp_l} is registered once (sample S). No other synchronisers are used; the inputs share clk.
- Run counter: resets to 1 when S differs from previous S, otherwise increments and saturates at 15.
- Accept: a sample is accepted in the single cycle the run counter equals STABLE_CYC. This gives one accept per dwell.
- Accepted, all anodes high: no capture.
- Accepted, exactly one anode i low:
  - staged seen[i]=1, staged dp[i]=~dp_l, staged digit[i]=decode(~segs_l).
  - A later accept of the same slot in the same frame overwrites it (last wins).
- Accepted, more than one anode low: multi_err=1; nothing is staged.
- Decode table (active-high gfedcba → nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
  - Any other pattern: nibble 0, seg_err=1, slot still marked seen.
- Frame timer: free-running 0..FRAME_CYC-1 from reset. On the cycle it equals FRAME_CYC-1, it publishes on the next edge:
  - digits/dpmask come from staging; blank=~seen. Unseen slots give digit 0 and dp 0.
  - frame_valid=1 for exactly that cycle.
  - An accept occurring in the publish cycle is merged into the published frame.
  - Staging then clears to empty.
- Latency: a driver slot visible at cycle N is accepted at N+STABLE_CYC and appears in the next publication.
- clear: drops seg_err/multi_err to 0 next edge. A new error in the same cycle wins (flag stays 1).
- Reset mid-frame: staging discarded; first publication occurs FRAME_CYC cycles after reset release.

Optional Feature:
SEVENSEG_CAPTURE_CHANGE_EN
- Defined: a previous-publication register (digits, blank, dpmask) is kept. changed pulses together with frame_valid when any published field differs from the previous publication. The first frame after reset is compared against the reset values.
- Undefined: the comparison register is absent and changed is tied to 0.

Test Plan:
1. Reset, hold anode_l=FF → every 8 cycles frame_valid pulses with blank=FF, digits=0, dpmask=0, no errors.
2. Emulate driver (one slot/clk, count 0..7) with d0..d7=0..7, blank=00, dpmask=01 → second publication gives digits=32'h76543210, blank=00, dpmask=01.
3. Same driver with blank=F0, d7..d4=F → blank=F0, digits[31:16]=0, dpmask bits 7..4=0.
4. Slot 2 driven with segs_l=7'h7F (no segments) → seg_err=1, digits[11:8]=0, blank[2]=0. Pulse clear → seg_err=0 next cycle.
5. anode_l=FC held → multi_err=1; slots 0/1 not captured (blank[1:0]=11).
6. STABLE_CYC=3, FRAME_CYC=32, 2-cycle glitch on slot 5 → glitch ignored. 3-cycle dwell → captured. Macro on, repeat identical frames → changed=1 only on the first.
